// File: rtl/gpio_input_conditioner.sv
// Pad input conditioner: 2-flop synchronizer, optional debounce (GPIO_INPUT_DEBOUNCE_EN),
// sticky W1C edge status with rise/fall enable masks and a registered level interrupt.
module gpio_input_conditioner #(
    parameter int          N_BITS    = 32,
    parameter int          DB_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR = 32'hFFFFFFF0
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [N_BITS-1:0] pad_in,
    output logic [N_BITS-1:0] io_in,
    input  logic [31:0]       data_address,
    input  logic              write_mem,
    input  logic              read_mem,
    input  logic [31:0]       data_to_write,
    output logic [31:0]       rd_data,
    output logic              rd_hit,
    output logic              irq
);

    localparam logic [31:0] RISE_ADDR = BASE_ADDR;
    localparam logic [31:0] FALL_ADDR = BASE_ADDR + 32'd4;
    localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd8;
    // Fall status lives at bits [31:16]; it only fits when there are at most 16 pads.
    localparam int          N_FALL    = (N_BITS > 16) ? 0 : N_BITS;

    logic [N_BITS-1:0] sync1_q, sync2_q;
    logic [N_BITS-1:0] stable_q, stable_d;
    logic [N_BITS-1:0] rise_en_q, rise_en_d;
    logic [N_BITS-1:0] fall_en_q, fall_en_d;
    logic [31:0]       stat_q, stat_d;
    logic              irq_q, irq_d;
    logic [31:0]       set_vec;
    logic [31:0]       w1c;

`ifdef GPIO_INPUT_DEBOUNCE_EN
    localparam int            CW      = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [N_BITS-1:0][CW-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < N_BITS; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign stable_d = sync2_q;
`endif

    always_comb begin
        set_vec             = '0;
        set_vec[N_BITS-1:0] = stable_d & ~stable_q & rise_en_q;
        for (int i = 0; i < N_FALL; i++) begin
            set_vec[16+i] = set_vec[16+i] | (~stable_d[i] & stable_q[i] & fall_en_q[i]);
        end
    end

    always_comb begin
        w1c       = '0;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        if (write_mem) begin
            if (data_address == RISE_ADDR) rise_en_d = data_to_write[N_BITS-1:0];
            if (data_address == FALL_ADDR) fall_en_d = data_to_write[N_BITS-1:0];
            if (data_address == STAT_ADDR) w1c = data_to_write;
        end
        // Set after clear so a same-cycle event survives its own W1C.
        stat_d = (stat_q & ~w1c) | set_vec;
        irq_d  = |stat_d;
    end

    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b0;
        if (read_mem) begin
            if (data_address == RISE_ADDR) begin
                rd_hit              = 1'b1;
                rd_data[N_BITS-1:0] = rise_en_q;
            end else if (data_address == FALL_ADDR) begin
                rd_hit              = 1'b1;
                rd_data[N_BITS-1:0] = fall_en_q;
            end else if (data_address == STAT_ADDR) begin
                rd_hit  = 1'b1;
                rd_data = stat_q;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            stat_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            sync1_q   <= pad_in;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            stat_q    <= stat_d;
            irq_q     <= irq_d;
        end
    end

    assign io_in = stable_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner (16 pads, 4-cycle debounce when enabled).
module tb_gpio_input_conditioner;

    localparam int          NB   = 16;
    localparam int          DB   = 4;
    localparam logic [31:0] BASE = 32'hFFFFFFF0;
`ifdef GPIO_INPUT_DEBOUNCE_EN
    localparam int LAT = 2 + DB;
`else
    localparam int LAT = 3;
`endif

    logic          clk;
    logic          nrst;
    logic [NB-1:0] pad_in;
    logic [NB-1:0] io_in;
    logic [31:0]   data_address;
    logic          write_mem;
    logic          read_mem;
    logic [31:0]   data_to_write;
    logic [31:0]   rd_data;
    logic          rd_hit;
    logic          irq;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_input_conditioner #(.N_BITS(NB), .DB_CYCLES(DB), .BASE_ADDR(BASE)) dut (
        .clk(clk), .nrst(nrst), .pad_in(pad_in), .io_in(io_in),
        .data_address(data_address), .write_mem(write_mem), .read_mem(read_mem),
        .data_to_write(data_to_write), .rd_data(rd_data), .rd_hit(rd_hit), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        data_address = addr;
        read_mem     = 1'b1;
        #1;
        chk({tag, "_hit"}, {31'b0, rd_hit}, 32'd1);
        chk(tag, rd_data, exp);
        read_mem = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        data_address  = addr;
        data_to_write = data;
        write_mem     = 1'b1;
        @(negedge clk);
        write_mem = 1'b0;
    endtask

    initial begin
        nrst = 1'b0; pad_in = 16'hFFFF; data_address = '0;
        write_mem = 1'b0; read_mem = 1'b0; data_to_write = '0;

        // Reset and release with all pads high
        cyc(3);
        chk("rst_io", {16'b0, io_in}, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        rd_chk("rst_rise_en", BASE, 32'h0);
        rd_chk("rst_fall_en", BASE + 32'd4, 32'h0);
        rd_chk("rst_stat", BASE + 32'd8, 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        cyc(LAT - 1);
        chk("rel_io_early", {16'b0, io_in}, 32'h0);
        cyc(1);
        chk("rel_io", {16'b0, io_in}, 32'h0000FFFF);
        rd_chk("rel_stat", BASE + 32'd8, 32'h0);

        // Rise on bit 0 with interrupt, then W1C
        pad_in = '0;
        cyc(LAT + 2);
        chk("low_io", {16'b0, io_in}, 32'h0);
        wr(BASE, 32'h1);
        pad_in[0] = 1'b1;
        cyc(LAT - 1);
        chk("rise_io_early", {16'b0, io_in}, 32'h0);
        chk("rise_irq_early", {31'b0, irq}, 32'h0);
        cyc(1);
        chk("rise_io", {16'b0, io_in}, 32'h1);
        rd_chk("rise_stat", BASE + 32'd8, 32'h1);
        chk("rise_irq", {31'b0, irq}, 32'h1);
        wr(BASE + 32'd8, 32'h1);
        rd_chk("w1c_stat", BASE + 32'd8, 32'h0);
        chk("w1c_irq", {31'b0, irq}, 32'h0);

        // Three-clock pulse on bit 3
        wr(BASE, 32'h9);
        pad_in[3] = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
`ifdef GPIO_INPUT_DEBOUNCE_EN
            chk($sformatf("glitch_io_%0d", i), {31'b0, io_in[3]}, 32'h0);
`else
            chk($sformatf("glitch_io_%0d", i), {31'b0, io_in[3]}, (i >= 3 && i <= 5) ? 32'h1 : 32'h0);
`endif
            if (i == 3) pad_in[3] = 1'b0;
        end
`ifdef GPIO_INPUT_DEBOUNCE_EN
        rd_chk("glitch_stat", BASE + 32'd8, 32'h0);
`else
        rd_chk("glitch_stat", BASE + 32'd8, 32'h8);
        wr(BASE + 32'd8, 32'h8);
        rd_chk("glitch_clr", BASE + 32'd8, 32'h0);
`endif

        // Fall on bit 2
        wr(BASE + 32'd4, 32'h4);
        pad_in[2] = 1'b1;
        cyc(LAT + 1);
        rd_chk("fall_pre_stat", BASE + 32'd8, 32'h0);
        pad_in[2] = 1'b0;
        cyc(LAT);
        rd_chk("fall_stat", BASE + 32'd8, 32'h0004_0000);
        chk("fall_irq", {31'b0, irq}, 32'h1);
        wr(BASE + 32'd8, 32'h0004_0000);
        chk("fall_clr_irq", {31'b0, irq}, 32'h0);

        // New rise on bit 0 in the same cycle as its W1C
        pad_in[0] = 1'b0;
        cyc(LAT + 1);
        pad_in[0] = 1'b1;
        cyc(LAT);
        rd_chk("col_first", BASE + 32'd8, 32'h1);
        pad_in[0] = 1'b0;
        cyc(LAT + 1);
        pad_in[0] = 1'b1;
        cyc(LAT - 1);
        wr(BASE + 32'd8, 32'h1);
        chk("col_io", {31'b0, io_in[0]}, 32'h1);
        rd_chk("col_stat", BASE + 32'd8, 32'h1);
        chk("col_irq", {31'b0, irq}, 32'h1);
        wr(BASE + 32'd8, 32'h1);
        rd_chk("col_clr", BASE + 32'd8, 32'h0);

        // Address decode and read-during-write
        data_address = BASE + 32'd12;
        read_mem     = 1'b1;
        #1;
        chk("dec_miss_hit", {31'b0, rd_hit}, 32'h0);
        chk("dec_miss_data", rd_data, 32'h0);
        data_address = BASE;
        read_mem     = 1'b0;
        #1;
        chk("dec_noread_hit", {31'b0, rd_hit}, 32'h0);
        chk("dec_noread_data", rd_data, 32'h0);
        rd_chk("dec_rise_en", BASE, 32'h9);
        rd_chk("dec_fall_en", BASE + 32'd4, 32'h4);
        @(negedge clk);
        data_address  = BASE;
        data_to_write = 32'hFFFF_0005;
        write_mem     = 1'b1;
        read_mem      = 1'b1;
        #1;
        chk("rw_old", rd_data, 32'h9);
        @(negedge clk);
        write_mem = 1'b0;
        read_mem  = 1'b0;
        rd_chk("rw_new", BASE, 32'h5);

        // Reset in the middle of a debounce
        pad_in[5] = 1'b1;
        cyc(3);
        nrst = 1'b0;
        #1;
        chk("mid_rst_io", {16'b0, io_in}, 32'h0);
        chk("mid_rst_irq", {31'b0, irq}, 32'h0);
        rd_chk("mid_rst_rise_en", BASE, 32'h0);
        nrst = 1'b1;
        cyc(LAT + 2);
        chk("post_rst_io", {16'b0, io_in}, 32'h0000_0021);
        rd_chk("post_rst_stat", BASE + 32'd8, 32'h0);
        chk("post_rst_irq", {31'b0, irq}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
